banked_local_memory_controller: RTL and testbench

//  Dual-master (core + Wishbone) front end for BANK_COUNT dual-port SRAM macros (1RW + 1R each).

---
 rtl/local_memory_pkg.sv | 26 ++
 rtl/local_memory_read_tracker.sv | 61 ++++++
 rtl/banked_local_memory_controller.sv | 152 +++++++++++++++
 tb/tb_banked_local_memory_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/local_memory_pkg.sv
// rtl/local_memory_pkg.sv - shared sizing helpers, window decode and read-tracker state
package local_memory_pkg;

    localparam int unsigned TRK_BANK_W = 8;
    localparam int unsigned TRK_SEL_W  = 16;

    typedef struct packed {
        logic                  ready;
        logic [TRK_BANK_W-1:0] bank;
        logic [TRK_SEL_W-1:0]  byte_sel;
    } read_trk_t;

    function automatic int unsigned bank_bits(input int unsigned bank_count);
        return $clog2(bank_count);
    endfunction

    function automatic int unsigned byte_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // An address hits the macro array only when nothing is set above the word index.
    function automatic logic in_window(input logic [63:0] addr, input int unsigned low_bits);
        return (addr >> low_bits) == 64'd0;
    endfunction

endpackage

// File: rtl/local_memory_read_tracker.sv
// rtl/local_memory_read_tracker.sv - two-cycle read handshake and byte-lane muxing for one master
module local_memory_read_tracker
    import local_memory_pkg::*;
#(
    parameter  int unsigned BANK_COUNT = 2,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned BYTES      = DATA_WIDTH / 8,
    localparam int unsigned BB         = bank_bits(BANK_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_i,
    input  logic                             grant_i,
    input  logic [BB-1:0]                    bank_i,
    input  logic [BYTES-1:0]                 byte_sel_i,
    input  logic [BANK_COUNT*DATA_WIDTH-1:0] dout_i,
    output logic                             ready_o,
    output logic                             busy_o,
    output logic [DATA_WIDTH-1:0]            data_o
);

    read_trk_t st_q, st_d;
    logic [DATA_WIDTH-1:0] word;
    logic unused_trk;

    // Ready lasts exactly one cycle: it clears when the request drops or is consumed.
    always_comb begin
        st_d = '0;
        if (req_i && !st_q.ready && grant_i) begin
            st_d.ready                = 1'b1;
            st_d.bank[BB-1:0]         = bank_i;
            st_d.byte_sel[BYTES-1:0]  = byte_sel_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) st_q <= '0;
        else     st_q <= st_d;
    end

    always_comb begin
        word = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (st_q.bank[BB-1:0] == BB'(b)) word = dout_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        data_o = '1;
        if (st_q.ready) begin
            for (int i = 0; i < BYTES; i++) begin
                if (st_q.byte_sel[i]) data_o[i*8 +: 8] = word[i*8 +: 8];
            end
        end
    end

    assign ready_o    = st_q.ready;
    assign busy_o     = req_i && !st_q.ready;
    assign unused_trk = ^st_q;

endmodule

// File: rtl/banked_local_memory_controller.sv
// rtl/banked_local_memory_controller.sv - core+WB front end for banked 1RW/1R SRAM; LOCAL_MEMORY_CONFLICT_COUNTER_EN adds conflict_count
module banked_local_memory_controller
    import local_memory_pkg::*;
#(
    parameter  int unsigned SRAM_ADDRESS_SIZE = 9,
    parameter  int unsigned BANK_COUNT        = 2,
    parameter  int unsigned DATA_WIDTH        = 32,
    parameter  int unsigned ADDRESS_WIDTH     = 24,
    parameter  int unsigned STARVE_LIMIT      = 4,
    localparam int unsigned BYTES             = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDRESS_WIDTH-1:0]         core_address,
    input  logic [BYTES-1:0]                 core_byte_select,
    input  logic                             core_enable,
    input  logic                             core_write_enable,
    input  logic [DATA_WIDTH-1:0]            core_data_write,
    output logic [DATA_WIDTH-1:0]            core_data_read,
    output logic                             core_busy,
    input  logic [ADDRESS_WIDTH-1:0]         wb_address,
    input  logic [BYTES-1:0]                 wb_byte_select,
    input  logic                             wb_enable,
    input  logic                             wb_write_enable,
    input  logic [DATA_WIDTH-1:0]            wb_data_write,
    output logic [DATA_WIDTH-1:0]            wb_data_read,
    output logic                             wb_busy,
    output logic                             clk0,
    output logic                             clk1,
    output logic [BANK_COUNT-1:0]            csb0,
    output logic [BANK_COUNT-1:0]            csb1,
    output logic                             web0,
    output logic [BYTES-1:0]                 wmask0,
    output logic [SRAM_ADDRESS_SIZE-1:0]     addr0,
    output logic [SRAM_ADDRESS_SIZE-1:0]     addr1,
    output logic [DATA_WIDTH-1:0]            din0,
    input  logic [BANK_COUNT*DATA_WIDTH-1:0] dout0,
    input  logic [BANK_COUNT*DATA_WIDTH-1:0] dout1
`ifdef LOCAL_MEMORY_CONFLICT_COUNTER_EN
    ,
    output logic [15:0]                      conflict_count
`endif
);

    localparam int unsigned BANK_BITS = bank_bits(BANK_COUNT);
    localparam int unsigned BYTE_BITS = byte_bits(DATA_WIDTH);
    localparam int unsigned WORD_BITS = SRAM_ADDRESS_SIZE + BANK_BITS;
    localparam int unsigned SW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [WORD_BITS-1:0] core_word, wb_word;
    logic [BANK_BITS-1:0] core_bank, wb_bank;
    logic core_in, wb_in;
    logic core_rd_req, core_wr_req, wb_rd_req, wb_wr_req, wb_rw_req;
    logic core_rd_busy, core_rd_ready, wb_rd_busy, wb_rd_ready;
    logic conflict, starve_full, override, core_grant, wb_grant, wb_loses;
    logic [SW-1:0] starve_q, starve_d;

    assign core_word = core_address[BYTE_BITS +: WORD_BITS];
    assign wb_word   = wb_address[BYTE_BITS +: WORD_BITS];
    assign core_bank = core_word[WORD_BITS-1 -: BANK_BITS];
    assign wb_bank   = wb_word[WORD_BITS-1 -: BANK_BITS];
    assign core_in   = in_window(64'(core_address), BYTE_BITS + WORD_BITS);
    assign wb_in     = in_window(64'(wb_address), BYTE_BITS + WORD_BITS);

    assign core_rd_req = core_enable && !core_write_enable && core_in;
    assign core_wr_req = core_enable && core_write_enable && core_in;
    assign wb_rd_req   = wb_enable && !wb_write_enable && wb_in;
    assign wb_wr_req   = wb_enable && wb_write_enable && wb_in;
    // A WB read in its data cycle no longer needs the RW port.
    assign wb_rw_req   = wb_wr_req || (wb_rd_req && !wb_rd_ready);

    assign conflict    = core_wr_req && wb_rw_req;
    assign starve_full = (STARVE_LIMIT != 0) && (starve_q == SW'(STARVE_LIMIT));
    assign override    = conflict && starve_full;
    assign core_grant  = core_wr_req && !override;
    assign wb_grant    = wb_rw_req && !core_grant;
    assign wb_loses    = conflict && !override;

    always_comb begin
        starve_d = starve_q;
        if (!wb_enable || wb_grant)
            starve_d = '0;
        else if (wb_loses && (starve_q < SW'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    local_memory_read_tracker #(.BANK_COUNT(BANK_COUNT), .DATA_WIDTH(DATA_WIDTH)) u_core_trk (
        .clk(clk), .rst(rst), .req_i(core_rd_req), .grant_i(1'b1), .bank_i(core_bank),
        .byte_sel_i(core_byte_select), .dout_i(dout1), .ready_o(core_rd_ready),
        .busy_o(core_rd_busy), .data_o(core_data_read)
    );

    local_memory_read_tracker #(.BANK_COUNT(BANK_COUNT), .DATA_WIDTH(DATA_WIDTH)) u_wb_trk (
        .clk(clk), .rst(rst), .req_i(wb_rd_req), .grant_i(wb_grant), .bank_i(wb_bank),
        .byte_sel_i(wb_byte_select), .dout_i(dout0), .ready_o(wb_rd_ready),
        .busy_o(wb_rd_busy), .data_o(wb_data_read)
    );

    assign core_busy = core_rd_busy || (core_wr_req && override);
    assign wb_busy   = wb_rd_busy || (wb_wr_req && !wb_grant);
    assign clk0      = clk;
    assign clk1      = clk;

    always_comb begin
        csb0   = '1;
        web0   = 1'b1;
        wmask0 = '0;
        din0   = '0;
        addr0  = '0;
        if (core_grant) begin
            csb0[core_bank] = 1'b0;
            web0            = 1'b0;
            wmask0          = core_byte_select;
            din0            = core_data_write;
            addr0           = core_word[SRAM_ADDRESS_SIZE-1:0];
        end else if (wb_grant) begin
            csb0[wb_bank]   = 1'b0;
            web0            = !wb_write_enable;
            wmask0          = wb_byte_select;
            din0            = wb_data_write;
            addr0           = wb_word[SRAM_ADDRESS_SIZE-1:0];
        end
    end

    always_comb begin
        csb1  = '1;
        addr1 = '0;
        if (core_rd_busy) begin
            csb1[core_bank] = 1'b0;
            addr1           = core_word[SRAM_ADDRESS_SIZE-1:0];
        end
    end

`ifdef LOCAL_MEMORY_CONFLICT_COUNTER_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk) begin
        if (rst)
            conflict_q <= '0;
        else if (wb_loses && (conflict_q != 16'hFFFF))
            conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_banked_local_memory_controller.sv
// tb/tb_banked_local_memory_controller.sv - directed-vector bench for banked_local_memory_controller
module tb_banked_local_memory_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] core_address, wb_address;
    logic [3:0]  core_byte_select, wb_byte_select;
    logic        core_enable, core_write_enable, wb_enable, wb_write_enable;
    logic [31:0] core_data_write, wb_data_write, core_data_read, wb_data_read;
    logic        core_busy, wb_busy, clk0, clk1, web0;
    logic [1:0]  csb0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0;
    logic [63:0] dout0, dout1;
`ifdef LOCAL_MEMORY_CONFLICT_COUNTER_EN
    logic [15:0] conflict_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    banked_local_memory_controller dut (
        .clk(clk), .rst(rst),
        .core_address(core_address), .core_byte_select(core_byte_select),
        .core_enable(core_enable), .core_write_enable(core_write_enable),
        .core_data_write(core_data_write), .core_data_read(core_data_read), .core_busy(core_busy),
        .wb_address(wb_address), .wb_byte_select(wb_byte_select),
        .wb_enable(wb_enable), .wb_write_enable(wb_write_enable),
        .wb_data_write(wb_data_write), .wb_data_read(wb_data_read), .wb_busy(wb_busy),
        .clk0(clk0), .clk1(clk1), .csb0(csb0), .csb1(csb1), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .addr1(addr1), .din0(din0), .dout0(dout0), .dout1(dout1)
`ifdef LOCAL_MEMORY_CONFLICT_COUNTER_EN
        , .conflict_count(conflict_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_enable = 1'b0; core_write_enable = 1'b0; core_address = '0;
        core_byte_select = '0; core_data_write = '0;
        wb_enable = 1'b0; wb_write_enable = 1'b0; wb_address = '0;
        wb_byte_select = '0; wb_data_write = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        dout0 = '0; dout1 = '0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0; #1;
        check("rst_csb0", csb0, 2'b11);
        check("rst_csb1", csb1, 2'b11);
        check("rst_web0", web0, 1'b1);
        check("rst_wmask0", wmask0, 4'h0);
        check("rst_din0", din0, 32'h0);
        check("rst_core_busy", core_busy, 1'b0);
        check("rst_wb_busy", wb_busy, 1'b0);
        check("rst_core_data", core_data_read, 32'hFFFFFFFF);
        check("rst_wb_data", wb_data_read, 32'hFFFFFFFF);

        // core read with partial byte select
        dout1 = {32'h0, 32'h11223344};
        core_enable = 1'b1; core_address = 24'h000004; core_byte_select = 4'b0101; #1;
        check("rd_busy", core_busy, 1'b1);
        check("rd_csb1", csb1, 2'b10);
        check("rd_addr1", addr1, 9'd1);
        tick();
        check("rd_done_busy", core_busy, 1'b0);
        check("rd_data", core_data_read, 32'hFF22FF44);
        idle(); tick();
        check("rd_ready_clear", core_data_read, 32'hFFFFFFFF);

        // out-of-window read
        core_enable = 1'b1; core_address = 24'h010000; core_byte_select = 4'hF; #1;
        check("oow_busy", core_busy, 1'b0);
        check("oow_data", core_data_read, 32'hFFFFFFFF);
        check("oow_csb1", csb1, 2'b11);
        idle(); tick();

        // simultaneous reads of bank1 from both masters
        dout0 = {32'hAABBCCDD, 32'h0};
        dout1 = {32'h55667788, 32'h0};
        core_enable = 1'b1; core_address = 24'h000804; core_byte_select = 4'hF;
        wb_enable = 1'b1; wb_address = 24'h000800; wb_byte_select = 4'hF; #1;
        check("dual_core_busy", core_busy, 1'b1);
        check("dual_wb_busy", wb_busy, 1'b1);
        check("dual_csb0", csb0, 2'b01);
        check("dual_csb1", csb1, 2'b01);
        tick();
        check("dual_core_done", core_busy, 1'b0);
        check("dual_wb_done", wb_busy, 1'b0);
        check("dual_core_data", core_data_read, 32'h55667788);
        check("dual_wb_data", wb_data_read, 32'hAABBCCDD);
        idle(); tick();

        // starvation guard: WB loses four conflicts then takes the RW port
        dout0 = {32'h0, 32'hCAFEF00D};
        core_enable = 1'b1; core_write_enable = 1'b1; core_address = 24'h000008;
        core_byte_select = 4'hF; core_data_write = 32'hDEADBEEF;
        wb_enable = 1'b1; wb_address = 24'h000010; wb_byte_select = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("starve_wb_busy", wb_busy, 1'b1);
            check("starve_core_busy", core_busy, 1'b0);
            check("starve_din0", din0, 32'hDEADBEEF);
            tick();
        end
        #1;
        check("grant_core_busy", core_busy, 1'b1);
        check("grant_web0", web0, 1'b1);
        check("grant_addr0", addr0, 9'd4);
        check("grant_csb0", csb0, 2'b10);
        tick();
        check("grant_wb_done", wb_busy, 1'b0);
        check("grant_wb_data", wb_data_read, 32'hCAFEF00D);
        check("grant_core_resume", core_busy, 1'b0);
        check("grant_core_web0", web0, 1'b0);
        idle(); tick();

        // RW port is shared, so a different-bank core write still blocks WB
        core_enable = 1'b1; core_write_enable = 1'b1; core_address = 24'h000800;
        core_byte_select = 4'hF; core_data_write = 32'h0BADF00D;
        wb_enable = 1'b1; wb_address = 24'h000000; wb_byte_select = 4'hF; #1;
        check("xbank_wb_busy", wb_busy, 1'b1);
        check("xbank_core_busy", core_busy, 1'b0);
        check("xbank_csb0", csb0, 2'b01);
        idle(); tick();

        // lone WB write
        wb_enable = 1'b1; wb_write_enable = 1'b1; wb_address = 24'h00080C;
        wb_byte_select = 4'b0011; wb_data_write = 32'h12345678; #1;
        check("wbwr_busy", wb_busy, 1'b0);
        check("wbwr_web0", web0, 1'b0);
        check("wbwr_wmask0", wmask0, 4'b0011);
        check("wbwr_din0", din0, 32'h12345678);
        check("wbwr_csb0", csb0, 2'b01);
        check("wbwr_addr0", addr0, 9'd3);
        idle(); tick();

        // reset during the read data cycle
        dout1 = {32'h0, 32'h11223344};
        core_enable = 1'b1; core_address = 24'h000004; core_byte_select = 4'b0101;
        tick();
        check("rstrd_data_pre", core_data_read, 32'hFF22FF44);
        rst = 1'b1;
        tick();
        check("rstrd_data_clr", core_data_read, 32'hFFFFFFFF);
        check("rstrd_busy", core_busy, 1'b1);
        rst = 1'b0; #1;
        check("rstrd_reissue", core_busy, 1'b1);
        tick();
        check("rstrd_done", core_busy, 1'b0);
        check("rstrd_data", core_data_read, 32'hFF22FF44);
        idle(); tick();

`ifdef LOCAL_MEMORY_CONFLICT_COUNTER_EN
        rst = 1'b1; tick(); rst = 1'b0;
        core_enable = 1'b1; core_write_enable = 1'b1; core_address = 24'h000000; core_byte_select = 4'hF;
        wb_enable = 1'b1; wb_write_enable = 1'b1; wb_address = 24'h000004; wb_byte_select = 4'hF;
        for (int i = 0; i < 12; i++) tick();
        check("conflict_count", conflict_count, 16'd10);
        idle(); tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
